fir_coeff_loader: RTL and testbench

Upstream coefficient-programming stage for the 4-tap FIR filter. Accepts a coefficient frame over a valid/ready write port, collects it in a shadow bank, checks frame framing, and atomically commits all four taps to registered outputs that drive the filter's `i_coeff0..3` ports. The filter never sees a partially updated coefficient set.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_coeff_loader.sv | 143 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the 4-tap FIR filter and its coefficient loader.
// Holds tap geometry, coefficient type, reset taps and loader states.
package fir_pkg;

    localparam int COEFF_W  = 16;
    localparam int NUM_TAPS = 4;

    typedef logic signed [COEFF_W-1:0] coeff_t;

    // Unity gain on tap 0 so the filter passes data through out of reset.
    localparam coeff_t COEFF_RESET [NUM_TAPS] = '{
        16'sh7FFF, 16'sh0000, 16'sh0000, 16'sh0000
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } ldr_state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Collects a coefficient frame into a shadow bank and commits all taps at once.
// Framing errors or aborts drop the frame and leave the active taps untouched.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = fir_pkg::NUM_TAPS,
    parameter int COEFF_W  = fir_pkg::COEFF_W
) (
    input  logic                      i_clk,
    input  logic                      i_rstb,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic signed [COEFF_W-1:0] i_wr_data,
    input  logic                      i_wr_last,
    input  logic                      i_abort,
    input  logic                      i_err_clr,
    output logic signed [COEFF_W-1:0] o_coeff0,
    output logic signed [COEFF_W-1:0] o_coeff1,
    output logic signed [COEFF_W-1:0] o_coeff2,
    output logic signed [COEFF_W-1:0] o_coeff3,
    output logic                      o_commit,
    output logic [7:0]                o_commit_cnt,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    ldr_state_t state_q, state_d;
    logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
    logic signed [COEFF_W-1:0] shadow_q [NUM_TAPS];
    logic signed [COEFF_W-1:0] shadow_d [NUM_TAPS];
    logic signed [COEFF_W-1:0] coeff_q [NUM_TAPS];
    logic signed [COEFF_W-1:0] coeff_d [NUM_TAPS];
    logic [7:0] commit_cnt_q, commit_cnt_d;
    logic commit_q, commit_d;
    logic err_q, err_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;

    logic accept;
    logic is_last_beat;
    logic frame_err;

    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        shadow_d     = shadow_q;
        coeff_d      = coeff_q;
        commit_cnt_d = commit_cnt_q;
        commit_d     = 1'b0;
        err_d        = err_q;
        frame_err    = 1'b0;
        accept       = i_wr_valid && ready_q;
        is_last_beat = (beat_idx_q == LAST_IDX);

        unique case (state_q)
            IDLE, LOAD: begin
                // Abort wins over a beat accepted in the same cycle.
                if (i_abort && (state_q == LOAD || accept)) begin
                    state_d    = IDLE;
                    beat_idx_d = '0;
                end else if (accept) begin
                    if (i_wr_last != is_last_beat) begin
                        frame_err  = 1'b1;
                        state_d    = IDLE;
                        beat_idx_d = '0;
                    end else begin
                        shadow_d[beat_idx_q] = i_wr_data;
                        if (is_last_beat) begin
                            state_d    = COMMIT;
                            beat_idx_d = '0;
                        end else begin
                            state_d    = LOAD;
                            beat_idx_d = beat_idx_q + 1'b1;
                        end
                    end
                end
            end
            COMMIT: begin
                coeff_d      = shadow_q;
                commit_cnt_d = commit_cnt_q + 8'd1;
                commit_d     = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d    = IDLE;
                beat_idx_d = '0;
            end
        endcase

        if (i_err_clr) begin
            err_d = 1'b0;
        end
        if (frame_err) begin
            err_d = 1'b1;
        end

        ready_d = (state_d != COMMIT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            state_q      <= IDLE;
            beat_idx_q   <= '0;
            commit_cnt_q <= '0;
            commit_q     <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                coeff_q[i] <= COEFF_RESET[i];
            end
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            commit_cnt_q <= commit_cnt_d;
            commit_q     <= commit_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            coeff_q      <= coeff_d;
        end
    end

    // Shadow contents only matter inside a frame, so no reset is needed.
    always_ff @(posedge i_clk) begin
        shadow_q <= shadow_d;
    end

    assign o_wr_ready   = ready_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;
    assign o_commit     = commit_q;
    assign o_commit_cnt = commit_cnt_q;
    assign o_coeff0     = coeff_q[0];
    assign o_coeff1     = coeff_q[1];
    assign o_coeff2     = coeff_q[2];
    assign o_coeff3     = coeff_q[3];

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a commit scoreboard.
module tb_fir_coeff_loader;

    logic clk;
    logic rstb;
    logic wr_valid;
    logic wr_ready;
    logic signed [15:0] wr_data;
    logic wr_last;
    logic abort_i;
    logic err_clr;
    logic signed [15:0] c0, c1, c2, c3;
    logic commit;
    logic [7:0] commit_cnt;
    logic busy;
    logic err;

    fir_coeff_loader dut (
        .i_clk        (clk),
        .i_rstb       (rstb),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_data    (wr_data),
        .i_wr_last    (wr_last),
        .i_abort      (abort_i),
        .i_err_clr    (err_clr),
        .o_coeff0     (c0),
        .o_coeff1     (c1),
        .o_coeff2     (c2),
        .o_coeff3     (c3),
        .o_commit     (commit),
        .o_commit_cnt (commit_cnt),
        .o_busy       (busy),
        .o_err        (err)
    );

    localparam logic [63:0] RST_TAPS = 64'h0000_0000_0000_7FFF;

    logic [63:0] coeffs;
    assign coeffs = {c3, c2, c1, c0};

    int checks;
    int errors;
    int stalls;
    logic [63:0] exp_q [$];
    logic [63:0] act;
    logic [7:0] exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                exp_cnt = 8'd0;
                act = RST_TAPS;
                exp_q.delete();
            end else if (commit) begin
                if (exp_q.size() == 0) begin
                    chk("commit_unexpected", 64'(commit), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    exp_cnt = exp_cnt + 8'd1;
                    chk("commit_coeffs", coeffs, e);
                    chk("commit_cnt", 64'(commit_cnt), 64'(exp_cnt));
                    act = e;
                end
            end
        end
    endtask

    task automatic send_beat(logic [15:0] d, logic l);
        wr_valid = 1'b1;
        wr_data = d;
        wr_last = l;
        for (int n = 0; n < 8 && !wr_ready; n++) begin
            step();
            stalls++;
        end
        if (!wr_ready) chk("ready_timeout", 64'(wr_ready), 64'd1);
        step();
        wr_valid = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic send_frame(logic [63:0] f);
        exp_q.push_back(f);
        for (int i = 0; i < 4; i++) begin
            send_beat(f[16*i +: 16], i == 3);
        end
    endtask

    initial begin
        logic [63:0] f;
        checks = 0;
        errors = 0;
        stalls = 0;
        act = RST_TAPS;
        exp_cnt = 8'd0;
        rstb = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        wr_last = 1'b0;
        abort_i = 1'b0;
        err_clr = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (3) step();
        chk("rst_coeffs", coeffs, RST_TAPS);
        chk("rst_cnt", 64'(commit_cnt), 64'd0);
        chk("rst_ready", 64'(wr_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_commit", 64'(commit), 64'd0);
        rstb = 1'b1;
        step();
        chk("ready_after_rst", 64'(wr_ready), 64'd1);

        f = 64'h0100_E000_2000_1000;
        send_frame(f);
        chk("commit_cycle_ready", 64'(wr_ready), 64'd0);
        chk("commit_cycle_busy", 64'(busy), 64'd1);
        chk("commit_cycle_old", coeffs, RST_TAPS);
        chk("commit_cycle_pulse", 64'(commit), 64'd0);
        step();
        chk("commit_pulse", 64'(commit), 64'd1);
        chk("commit_new", coeffs, f);
        chk("commit_cnt1", 64'(commit_cnt), 64'd1);
        chk("commit_ready_back", 64'(wr_ready), 64'd1);
        step();
        chk("commit_pulse_end", 64'(commit), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        send_beat(16'h1111, 1'b0);
        send_beat(16'h2222, 1'b1);
        chk("err_beat1", 64'(err), 64'd1);
        chk("err_beat1_idle", 64'(busy), 64'd0);
        chk("err_beat1_keep", coeffs, act);
        f = 64'h7654_8000_0ABC_1234;
        send_frame(f);
        step();
        step();
        chk("err_frame_taps", coeffs, f);
        chk("err_sticky", 64'(err), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr", 64'(err), 64'd0);

        err_clr = 1'b1;
        send_beat(16'h3333, 1'b1);
        err_clr = 1'b0;
        chk("err_set_wins", 64'(err), 64'd1);
        chk("err_beat0_idle", 64'(busy), 64'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        for (int i = 0; i < 4; i++) send_beat(16'(i + 5), 1'b0);
        chk("err_nolast", 64'(err), 64'd1);
        chk("err_nolast_idle", 64'(busy), 64'd0);
        step();
        step();
        chk("err_nolast_cnt", 64'(commit_cnt), 64'(exp_cnt));
        chk("err_nolast_keep", coeffs, act);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        send_beat(16'h0AAA, 1'b0);
        send_beat(16'h0BBB, 1'b0);
        wr_valid = 1'b1;
        wr_data = 16'h0CCC;
        abort_i = 1'b1;
        step();
        wr_valid = 1'b0;
        abort_i = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        step();
        chk("abort_no_commit", 64'(commit), 64'd0);
        f = 64'h0004_0003_0002_0001;
        send_frame(f);
        step();
        step();
        chk("abort_next_frame", coeffs, f);

        f = 64'hFFFF_0001_7FFF_8000;
        send_frame(f);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_in_commit", 64'(commit), 64'd1);
        chk("abort_in_commit_taps", coeffs, f);
        step();

        send_beat(16'h1111, 1'b0);
        send_beat(16'h2222, 1'b0);
        send_beat(16'h3333, 1'b0);
        rstb = 1'b0;
        step();
        chk("midrst_coeffs", coeffs, RST_TAPS);
        chk("midrst_cnt", 64'(commit_cnt), 64'd0);
        chk("midrst_ready", 64'(wr_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        step();
        rstb = 1'b1;
        step();
        f = 64'h0040_0030_0020_0010;
        send_frame(f);
        step();
        step();
        chk("midrst_frame", coeffs, f);
        chk("midrst_cnt1", 64'(commit_cnt), 64'd1);

        rstb = 1'b0;
        step();
        step();
        rstb = 1'b1;
        step();
        stalls = 0;
        for (int k = 0; k < 256; k++) begin
            send_frame({$urandom, $urandom});
        end
        step();
        step();
        chk("stream_stalls", 64'(stalls), 64'd255);
        chk("stream_cnt_wrap", 64'(commit_cnt), 64'd0);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
